jb_aes_block_sequencer: RTL

- Hardware initiator for one JawBreaker AES core (JB_AES_Encrypt or JB_AES_Decrypt) using the core's active-low nStart/nDone handshake.
- Upstream side: a valid/ready stream of {key, block} requests. Downstream side: a valid/ready stream of result blocks.
- Issues the nStart pulse, holds key/blockin stable, detects completion, captures blockout, and aborts on timeout.
- Sits between a host/DMA stream and a single AES core instance.

---
 rtl/jb_aes_block_sequencer.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/jb_aes_block_sequencer.sv
// ---------------------------------------------------------------------------
// jb_aes_block_sequencer
//
// Purpose:
//   Drives a single JawBreaker AES core (encrypt or decrypt) via its
//   active-low nStart/nDone handshake. Requests {key, block} arrive on a
//   valid/ready stream. Results leave on a valid/ready stream. One block is
//   in flight at a time. A stalled core is abandoned after TIMEOUT_CYCLES
//   cycles in WAIT, and the sticky timeout_err flag is raised.
//
// Optional feature:
//   `define JB_SEQ_LATENCY_EN adds the last_latency[15:0] output. It holds
//   the number of cycles from START through the completion cycle of the most
//   recent successful operation, and saturates at 16'hFFFF.
//
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   in_valid      request valid
//   in_ready      request accepted when high (IDLE and not in reset)
//   in_key        request key
//   in_block      request data block
//   out_valid     result valid
//   out_ready     downstream accepts result
//   out_block     result block, held while out_valid
//   core_nRst     core reset, active-low, combinational ~rst
//   core_nStart   core start, one-cycle active-low pulse
//   core_key      key presented to core, stable from handshake to handshake
//   core_blockin  block presented to core, stable from handshake to handshake
//   core_nDone    core done, active-low; completion is a sampled falling edge
//   core_blockout core result
//   busy          sequencer is not IDLE
//   timeout_err   sticky abort flag, cleared only by rst
//   last_latency  (JB_SEQ_LATENCY_EN only) cycles START..completion
// ---------------------------------------------------------------------------
module jb_aes_block_sequencer #(
    parameter int BLOCK_WIDTH    = 128,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [BLOCK_WIDTH-1:0] in_key,
    input  logic [BLOCK_WIDTH-1:0] in_block,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [BLOCK_WIDTH-1:0] out_block,
    output logic                   core_nRst,
    output logic                   core_nStart,
    output logic [BLOCK_WIDTH-1:0] core_key,
    output logic [BLOCK_WIDTH-1:0] core_blockin,
    input  logic                   core_nDone,
    input  logic [BLOCK_WIDTH-1:0] core_blockout,
    output logic                   busy,
    output logic                   timeout_err
`ifdef JB_SEQ_LATENCY_EN
    ,
    output logic [15:0]            last_latency
`endif
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_OUTPUT
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             ndone_q;
    logic             done_edge;

    // A falling edge of nDone, seen as "previously high, now low", marks
    // completion. Only meaningful while in WAIT.
    assign done_edge = ndone_q && !core_nDone;

    assign core_nRst = ~rst;
    assign in_ready  = !rst && (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);

    // NOTE: every register below is written with non-blocking assignments so
    // all state updates on one edge see the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the wide data registers are reset too, so a reset is
            // visible on core_key/core_blockin and no stale result survives.
            state        <= ST_IDLE;
            core_nStart  <= 1'b1;
            out_valid    <= 1'b0;
            out_block    <= '0;
            core_key     <= '0;
            core_blockin <= '0;
            timeout_err  <= 1'b0;
            wait_cnt     <= '0;
            ndone_q      <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        core_key     <= in_key;
                        core_blockin <= in_block;
                        core_nStart  <= 1'b0;
                        state        <= ST_START;
                    end
                end

                ST_START: begin
                    // nDone is ignored here; arming ndone_q high means the
                    // first low level sampled in WAIT counts as the edge.
                    core_nStart <= 1'b1;
                    ndone_q     <= 1'b1;
                    wait_cnt    <= '0;
                    state       <= ST_WAIT;
                end

                ST_WAIT: begin
                    ndone_q <= core_nDone;
                    // Completion is checked first so it wins over a timeout
                    // landing on the same cycle.
                    if (done_edge) begin
                        out_block <= core_blockout;
                        out_valid <= 1'b1;
                        state     <= ST_OUTPUT;
                    end else if (wait_cnt == CNT_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end

                ST_OUTPUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef JB_SEQ_LATENCY_EN
    // lat_cnt holds the cycles already spent in this operation before the
    // current cycle; adding one counts the current cycle inclusively.
    logic [15:0] lat_cnt;
    logic [15:0] lat_next;

    assign lat_next = (lat_cnt == 16'hFFFF) ? lat_cnt : lat_cnt + 16'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            lat_cnt      <= '0;
            last_latency <= '0;
        end else begin
            case (state)
                ST_START: lat_cnt <= 16'd1;
                ST_WAIT: begin
                    if (done_edge) begin
                        last_latency <= lat_next;
                    end else begin
                        lat_cnt <= lat_next;
                    end
                end
                default: ;
            endcase
        end
    end
`endif

endmodule
